// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: CPU LSU on port 0,
// loader/debug DMA on port 1. Each access takes IDLE -> ACCESS -> RESP; all outputs are registered.
module dmem_arbiter #(
    parameter int AW        = 10,
    parameter int DW        = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          WR0,
    input  logic [AW-1:0] ADDR0,
    input  logic [DW-1:0] WDATA0,
    output logic          ACK0,
    output logic [DW-1:0] RDATA0,
    input  logic          REQ1,
    input  logic          WR1,
    input  logic [AW-1:0] ADDR1,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK1,
    output logic [DW-1:0] RDATA1,
    output logic          MEM_WE,
    output logic [AW-1:0] MEM_ADDRESS,
    output logic [DW-1:0] MEM_DATA,
    input  logic [DW-1:0] MEM_Q,
    output logic          BUSY,
    output logic [1:0]    dbg_state
);

    // Handshake: a port holds REQ until it sees its one-cycle ACK. A REQ still
    // high in the cycle after ACK counts as a new request. Dropping REQ before
    // the grant withdraws it; after the grant the access always completes.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_q, last_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          ack0_q, ack0_d;
    logic          ack1_q, ack1_d;
    logic [DW-1:0] rdata0_q, rdata0_d;
    logic [DW-1:0] rdata1_q, rdata1_d;
    logic          busy_q, busy_d;
    logic          pick1;

    // In round-robin mode a tie goes to the port that was not granted last.
    always_comb begin
        if (PRIO_MODE == 1) pick1 = ~REQ0 & REQ1;
        else                pick1 = REQ1 & (~REQ0 | ~last_q);
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        ack0_d     = 1'b0;
        ack1_d     = 1'b0;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;
        case (state_q)
            ST_IDLE: begin
                if (REQ0 | REQ1) begin
                    gnt_d      = pick1;
                    last_d     = pick1;
                    mem_we_d   = pick1 ? WR1 : WR0;
                    mem_addr_d = pick1 ? ADDR1 : ADDR0;
                    mem_data_d = pick1 ? WDATA1 : WDATA0;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Writes also capture MEM_Q; that word is the pre-write data and is meaningless.
                mem_we_d = 1'b0;
                if (gnt_q) begin
                    rdata1_d = MEM_Q;
                    ack1_d   = 1'b1;
                end else begin
                    rdata0_d = MEM_Q;
                    ack0_d   = 1'b1;
                end
                state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            last_q     <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            busy_q     <= busy_d;
        end
    end

    assign ACK0        = ack0_q;
    assign ACK1        = ack1_q;
    assign RDATA0      = rdata0_q;
    assign RDATA1      = rdata1_q;
    assign MEM_WE      = mem_we_q;
    assign MEM_ADDRESS = mem_addr_q;
    assign MEM_DATA    = mem_data_q;
    assign BUSY        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one round-robin instance and one fixed-priority instance,
// each with its own behavioural 1024x32 memory.
module tb_dmem_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, wr0 = 1'b0, req1 = 1'b0, wr1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;

    logic          a_ack0, a_ack1, a_we, a_busy;
    logic [DW-1:0] a_rdata0, a_rdata1, a_data, a_q;
    logic [AW-1:0] a_addr;
    logic [1:0]    a_state;
    logic          b_ack0, b_ack1, b_we, b_busy;
    logic [DW-1:0] b_rdata0, b_rdata1, b_data, b_q;
    logic [AW-1:0] b_addr;
    logic [1:0]    b_state;

    logic [DW-1:0] mem_a [0:1023];
    logic [DW-1:0] mem_b [0:1023];
    logic [DW-1:0] ref_mem [0:1023];

    int total = 0;
    int bad   = 0;

    dmem_arbiter #(.AW(AW), .DW(DW), .PRIO_MODE(0)) dut0 (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .WR0(wr0), .ADDR0(addr0), .WDATA0(wdata0), .ACK0(a_ack0), .RDATA0(a_rdata0),
        .REQ1(req1), .WR1(wr1), .ADDR1(addr1), .WDATA1(wdata1), .ACK1(a_ack1), .RDATA1(a_rdata1),
        .MEM_WE(a_we), .MEM_ADDRESS(a_addr), .MEM_DATA(a_data), .MEM_Q(a_q),
        .BUSY(a_busy), .dbg_state(a_state)
    );

    dmem_arbiter #(.AW(AW), .DW(DW), .PRIO_MODE(1)) dut1 (
        .CLK(clk), .RST(rst),
        .REQ0(req0), .WR0(wr0), .ADDR0(addr0), .WDATA0(wdata0), .ACK0(b_ack0), .RDATA0(b_rdata0),
        .REQ1(req1), .WR1(wr1), .ADDR1(addr1), .WDATA1(wdata1), .ACK1(b_ack1), .RDATA1(b_rdata1),
        .MEM_WE(b_we), .MEM_ADDRESS(b_addr), .MEM_DATA(b_data), .MEM_Q(b_q),
        .BUSY(b_busy), .dbg_state(b_state)
    );

    // clock / memories (cleared while reset is held across an edge)
    always #5 clk = ~clk;

    assign a_q = mem_a[a_addr];
    assign b_q = mem_b[b_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 1024; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
        end else begin
            if (a_we) mem_a[a_addr] <= a_data;
            if (b_we) mem_b[b_addr] <= b_data;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int p, input logic rq, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        if (p == 0) begin
            req0 = rq; wr0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = rq; wr1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // table-driven single-port transactions
    typedef struct {
        int            port;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          chg;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    task automatic run_vec(input int idx, input vec_t v);
        int            lat, we_cnt, oth;
        logic          got, own_ack, oth_ack;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd, rd;
        string         tag;
        tag = $sformatf("vec%0d", idx);
        lat = -1; we_cnt = 0; oth = 0; got = 1'b0; wa = '0; wd = '0; rd = '0;
        @(negedge clk);
        drive(v.port, 1'b1, v.wr, v.addr, v.wdata);
        for (int c = 1; c <= 10 && !got; c++) begin
            @(negedge clk);
            if (c == 1 && v.chg) drive(v.port, 1'b1, v.wr, 10'h3FF, ~v.wdata);
            own_ack = (v.port == 0) ? a_ack0 : a_ack1;
            oth_ack = (v.port == 0) ? a_ack1 : a_ack0;
            if (a_we) begin
                we_cnt++; wa = a_addr; wd = a_data;
            end
            if (oth_ack) oth++;
            if (own_ack) begin
                lat = c;
                rd  = (v.port == 0) ? a_rdata0 : a_rdata1;
                got = 1'b1;
            end
        end
        drive(v.port, 1'b0, 1'b0, '0, '0);
        check({tag, "_ack_latency"}, 64'(lat), 64'd2);
        check({tag, "_we_pulses"}, 64'(we_cnt), v.wr ? 64'd1 : 64'd0);
        check({tag, "_other_ack"}, 64'(oth), 64'd0);
        if (v.wr) begin
            check({tag, "_we_addr"}, 64'(wa), 64'(v.addr));
            check({tag, "_we_data"}, 64'(wd), 64'(v.wdata));
        end else begin
            check({tag, "_rdata"}, 64'(rd), 64'(v.exp_rd));
        end
        @(negedge clk);
        check({tag, "_ack_dropped"}, {62'd0, a_ack1, a_ack0}, 64'd0);
        check({tag, "_busy_after"}, 64'(a_busy), 64'd0);
    endtask

    // random-traffic state per port
    logic          r_act [2];
    logic          r_wr [2];
    logic [AW-1:0] r_addr [2];
    logic [DW-1:0] r_data [2];
    int            r_wait [2];
    int            r_cool [2];

    logic [0:0] exp_q [$];
    logic [0:0] got_a [$];
    logic [0:0] got_b [$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 1'b1, 10'h005, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[1] = '{1, 1'b0, 10'h005, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2] = '{0, 1'b1, 10'h005, 32'h12345678, 1'b1, 32'h0};
        vecs[3] = '{1, 1'b0, 10'h005, 32'h0,        1'b0, 32'h12345678};
        vecs[4] = '{1, 1'b1, 10'h3FF, 32'hCAFEF00D, 1'b0, 32'h0};
        vecs[5] = '{0, 1'b0, 10'h3FF, 32'h0,        1'b0, 32'hCAFEF00D};
        vecs[6] = '{1, 1'b0, 10'h000, 32'h0,        1'b1, 32'h0};
        vecs[7] = '{1, 1'b1, 10'h001, 32'h0BADF00D, 1'b0, 32'h0};
        vecs[8] = '{0, 1'b0, 10'h001, 32'h0,        1'b0, 32'h0BADF00D};

        // reset values
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_outputs", {a_ack0, a_ack1, a_we, a_busy}, 64'd0);
        check("reset_addr_data", {a_addr, a_data}, 64'd0);
        check("reset_rdata", {a_rdata0, a_rdata1}, 64'd0);

        // asynchronous reset in the middle of a write
        drive(0, 1'b1, 1'b1, 10'h005, 32'h11111111);
        @(negedge clk);
        check("t1_we_before_reset", 64'(a_we), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("t1_async_we", 64'(a_we), 64'd0);
        check("t1_async_busy", 64'(a_busy), 64'd0);
        check("t1_async_ack", {a_ack1, a_ack0}, 64'd0);
        check("t1_async_state", 64'(a_state), 64'd0);
        drive(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        begin
            int acks;
            acks = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (a_ack0 || a_ack1) acks++;
            end
            check("t1_no_ack_after_reset", 64'(acks), 64'd0);
        end

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // port 1 withdraws its request before it is granted
        begin
            int ack1s, wes;
            ack1s = 0; wes = 0;
            @(negedge clk);
            drive(0, 1'b1, 1'b0, 10'h3FF, '0);
            @(negedge clk);
            drive(1, 1'b1, 1'b1, 10'h002, 32'h77777777);
            @(negedge clk);
            check("t6_p0_ack", 64'(a_ack0), 64'd1);
            check("t6_p0_rdata", 64'(a_rdata0), 64'hCAFEF00D);
            drive(0, 1'b0, 1'b0, '0, '0);
            drive(1, 1'b0, 1'b0, '0, '0);
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (a_ack1) ack1s++;
                if (a_we) wes++;
            end
            check("t6_no_ack1", 64'(ack1s), 64'd0);
            check("t6_no_write", 64'(wes), 64'd0);
            check("t6_mem2_untouched", 64'(mem_a[2]), 64'd0);
        end

        // both ports held for 12 cycles: mode 0 alternates, mode 1 serves port 0 only
        do_reset();
        drive(0, 1'b1, 1'b0, 10'h010, '0);
        drive(1, 1'b1, 1'b0, 10'h020, '0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (a_ack0) got_a.push_back(1'b0);
            if (a_ack1) got_a.push_back(1'b1);
            if (b_ack0) got_b.push_back(1'b0);
            if (b_ack1) got_b.push_back(1'b1);
            if (a_ack0 && a_ack1) check("t4_dual_ack_mode0", 64'd1, 64'd0);
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        exp_q = '{1'b0, 1'b1, 1'b0, 1'b1};
        check("t4_mode0_count", 64'(got_a.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_a.size(); i++)
            check($sformatf("t4_mode0_grant%0d", i), 64'(got_a[i]), 64'(exp_q[i]));
        exp_q = '{1'b0, 1'b0, 1'b0, 1'b0};
        check("t4_mode1_count", 64'(got_b.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_b.size(); i++)
            check($sformatf("t4_mode1_grant%0d", i), 64'(got_b[i]), 64'(exp_q[i]));

        // random traffic on the round-robin instance against a transaction-level model
        do_reset();
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        for (int p = 0; p < 2; p++) begin
            r_act[p] = 1'b0; r_wr[p] = 1'b0; r_addr[p] = '0; r_data[p] = '0;
            r_wait[p] = 0; r_cool[p] = 0;
        end
        for (int cyc = 0; cyc < 500; cyc++) begin
            logic [1:0] ackv;
            logic       found;
            @(negedge clk);
            ackv = {a_ack1, a_ack0};
            if (ackv != 2'b00) check("rnd_single_ack", 64'(ackv == 2'b11), 64'd0);
            if (a_we) begin
                found = 1'b0;
                for (int p = 0; p < 2; p++)
                    if (r_act[p] && r_wr[p] && r_addr[p] == a_addr && r_data[p] == a_data) found = 1'b1;
                check("rnd_we_matches_request", 64'(found), 64'd1);
            end
            for (int p = 0; p < 2; p++) begin
                if (ackv[p]) begin
                    check($sformatf("rnd_ack_had_req_p%0d", p), 64'(r_act[p]), 64'd1);
                    if (r_act[p]) begin
                        if (r_wr[p]) ref_mem[r_addr[p]] = r_data[p];
                        else check($sformatf("rnd_rdata_p%0d", p),
                                   64'((p == 0) ? a_rdata0 : a_rdata1), 64'(ref_mem[r_addr[p]]));
                        check($sformatf("rnd_wait_bound_p%0d", p), 64'(r_wait[p] <= 4), 64'd1);
                    end
                    r_act[p] = 1'b0;
                    drive(p, 1'b0, 1'b0, '0, '0);
                    r_cool[p] = $urandom_range(1, 3);
                end else if (r_act[p]) begin
                    r_wait[p]++;
                    if (r_wait[p] > 12) begin
                        check($sformatf("rnd_timeout_p%0d", p), 64'(r_wait[p]), 64'd4);
                        r_act[p] = 1'b0;
                        drive(p, 1'b0, 1'b0, '0, '0);
                        r_cool[p] = 3;
                    end
                end else if (r_cool[p] > 0) begin
                    r_cool[p]--;
                end else if ($urandom_range(0, 2) == 0) begin
                    int sel;
                    sel = $urandom_range(0, 8);
                    r_act[p]  = 1'b1;
                    r_wait[p] = 0;
                    r_wr[p]   = 1'($urandom_range(0, 1));
                    r_addr[p] = (sel == 8) ? 10'h3FE : 10'(10'h100 + sel);
                    r_data[p] = $urandom;
                    drive(p, 1'b1, r_wr[p], r_addr[p], r_data[p]);
                end
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
